// File: rtl/iir_out_fifo.sv
// rtl/iir_out_fifo.sv - first-word-fall-through output buffer behind the myiir filter
//
// Purpose: captures the filter's non-backpressured sample stream and presents
// it to a consumer through a valid/ready handshake. It absorbs short consumer
// stalls and reports dropped samples through a sticky overrun flag.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_n    in   asynchronous active-low reset
//   DIN      in   NB-bit sample from the filter
//   VIN      in   sample valid from the filter
//   RDY      in   consumer ready
//   OVF_CLR  in   synchronous clear of OVF
//   DOUT     out  head-of-queue sample, 0 when VOUT=0
//   VOUT     out  head sample valid (queue non-empty)
//   FULL     out  COUNT == DEPTH
//   EMPTY    out  COUNT == 0
//   COUNT    out  number of stored samples
//   OVF      out  sticky overrun flag
module iir_out_fifo #(
  parameter int NB    = 13,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic [NB-1:0]              DIN,
  input  logic                       VIN,
  input  logic                       RDY,
  input  logic                       OVF_CLR,
  output logic [NB-1:0]              DOUT,
  output logic                       VOUT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [NB-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rd_en;
  logic          wr_en;
  logic          overrun;

  // Pointers carry one extra MSB so that equal low bits with differing MSB
  // means full; the difference is therefore the occupancy directly.
  assign COUNT = wr_ptr - rd_ptr;
  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (COUNT == FULL_CNT);
  assign VOUT  = ~EMPTY;
  assign DOUT  = VOUT ? mem[rd_ptr[AW-1:0]] : '0;

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // write when the consumer is reading.
  assign rd_en   = VOUT & RDY;
  assign wr_en   = VIN & (~FULL | rd_en);
  assign overrun = VIN & FULL & ~rd_en;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= DIN;
  end

  // Set has priority over clear so a coincident overrun is never lost.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      OVF <= 1'b0;
    end else if (overrun) begin
      OVF <= 1'b1;
    end else if (OVF_CLR) begin
      OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir_out_fifo.sv
// tb/tb_iir_out_fifo.sv - directed self-checking bench for iir_out_fifo
//
// Purpose: exercises reset, pass-through, fill/overrun, full read+write,
// wrap-around against a queue scoreboard, and overflow clearing.
// Ports: none (top-level bench).
module tb_iir_out_fifo;

  logic        clk;
  logic        rst_n;
  logic [12:0] din;
  logic        vin;
  logic        rdy;
  logic        ovf_clr;
  logic [12:0] dout;
  logic        vout;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [12:0] vals [8];

  iir_out_fifo #(.NB(13), .DEPTH(8)) dut (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin), .RDY(rdy),
    .OVF_CLR(ovf_clr), .DOUT(dout), .VOUT(vout), .FULL(full),
    .EMPTY(empty), .COUNT(count), .OVF(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vin = 1'b0; rdy = 1'b0; ovf_clr = 1'b0; din = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_vals();
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = vals[i];
      tick();
    end
    vin = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (vout !== 1'b0 || dout !== 13'h0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_init got vout=%b dout=%h count=%0d empty=%b full=%b ovf=%b exp 0 0 0 1 0 0", vout, dout, count, empty, full, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1; din = 13'(10 + i);
      tick();
    end
    vin = 1'b0;
    checks++; if (count !== 4'd3 || dout !== 13'd10) begin
      errors++; $display("FAIL reset_prefill got count=%0d dout=%h exp 3 00a", count, dout);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vout !== 1'b0 || dout !== 13'h0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_async got vout=%b dout=%h count=%0d empty=%b full=%b exp 0 0 0 1 0", vout, dout, count, empty, full);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 4'd0 || empty !== 1'b1 || vout !== 1'b0) begin
      errors++; $display("FAIL reset_release got count=%0d empty=%b vout=%b exp 0 1 0", count, empty, vout);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vin = 1'b1; din = 13'(i);
      tick();
      checks++; if (vout !== 1'b1 || dout !== 13'(i)) begin
        errors++; $display("FAIL pass_dout i=%0d got vout=%b dout=%h exp 1 %h", i, vout, dout, 13'(i));
      end
      checks++; if (count !== 4'd1 || ovf !== 1'b0) begin
        errors++; $display("FAIL pass_count i=%0d got count=%0d ovf=%b exp 1 0", i, count, ovf);
      end
    end
    vin = 1'b0;
    tick();
    checks++; if (empty !== 1'b1 || dout !== 13'h0) begin
      errors++; $display("FAIL pass_drain got empty=%b dout=%h exp 1 0", empty, dout);
    end
  endtask

  task automatic test_fill_overrun();
    do_reset();
    fill_vals();
    checks++; if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin
      errors++; $display("FAIL fill_full got full=%b count=%0d ovf=%b exp 1 8 0", full, count, ovf);
    end
    vin = 1'b1; din = 13'd555;
    tick();
    vin = 1'b0;
    checks++; if (ovf !== 1'b1 || count !== 4'd8 || dout !== 13'h1000) begin
      errors++; $display("FAIL overrun got ovf=%b count=%0d dout=%h exp 1 8 1000", ovf, count, dout);
    end
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (vout !== 1'b1 || dout !== vals[i]) begin
        errors++; $display("FAIL drain i=%0d got vout=%b dout=%h exp 1 %h", i, vout, dout, vals[i]);
      end
      tick();
    end
    checks++; if (empty !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL drain_end got empty=%b ovf=%b exp 1 1", empty, ovf);
    end
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b exp 0", ovf);
    end
    fill_vals();
    vin = 1'b1; din = 13'd777; ovf_clr = 1'b1;
    tick();
    vin = 1'b0; ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL ovf_set_wins got ovf=%b count=%0d exp 1 8", ovf, count);
    end
    tick();
    checks++; if (ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b exp 1", ovf);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    fill_vals();
    vin = 1'b1; din = 13'h0abc; rdy = 1'b1;
    tick();
    vin = 1'b0;
    checks++; if (count !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL full_rw got count=%0d full=%b ovf=%b exp 8 1 0", count, full, ovf);
    end
    for (int i = 1; i < 8; i++) begin
      checks++; if (dout !== vals[i]) begin
        errors++; $display("FAIL full_rw_order i=%0d got %h exp %h", i, dout, vals[i]);
      end
      tick();
    end
    checks++; if (dout !== 13'h0abc || vout !== 1'b1) begin
      errors++; $display("FAIL full_rw_new got dout=%h vout=%b exp 0abc 1", dout, vout);
    end
    tick();
    checks++; if (empty !== 1'b1) begin
      errors++; $display("FAIL full_rw_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_wrap();
    logic [12:0] exp_q[$];
    logic        ovr_seen;
    logic        was_full;
    logic        rd;
    int          writes;
    int          reads;
    do_reset();
    ovr_seen = 1'b0;
    writes = 0;
    reads = 0;
    for (int c = 0; c < 50; c++) begin
      vin = 1'b1;
      din = 13'(300 + c);
      rdy = 1'($urandom_range(0, 1));
      #1;
      was_full = (exp_q.size() == 8);
      rd = (exp_q.size() > 0) && rdy;
      if (rd) begin
        checks++; if (dout !== exp_q[0]) begin
          errors++; $display("FAIL wrap_data c=%0d got %h exp %h", c, dout, exp_q[0]);
        end
        void'(exp_q.pop_front());
        reads++;
      end
      if (!was_full || rd) begin
        exp_q.push_back(13'(300 + c));
        writes++;
      end else begin
        ovr_seen = 1'b1;
      end
      tick();
      checks++; if (count !== 4'(writes - reads) || ovf !== ovr_seen) begin
        errors++; $display("FAIL wrap_state c=%0d got count=%0d ovf=%b exp %0d %b", c, count, ovf, writes - reads, ovr_seen);
      end
    end
    vin = 1'b0;
    rdy = 1'b1;
    while (exp_q.size() > 0) begin
      checks++; if (dout !== exp_q[0]) begin
        errors++; $display("FAIL wrap_tail got %h exp %h", dout, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    checks++; if (empty !== 1'b1) begin
      errors++; $display("FAIL wrap_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_reset_midstream();
    rdy = 1'b0;
    fill_vals();
    vin = 1'b1; din = 13'd1;
    tick();
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ovf !== 1'b0 || full !== 1'b0 || count !== 4'd0 || vout !== 1'b0 || dout !== 13'h0) begin
      errors++; $display("FAIL reset_mid got ovf=%b full=%b count=%0d vout=%b dout=%h exp 0 0 0 0 0", ovf, full, count, vout, dout);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vals[0] = 13'h1000; vals[1] = 13'h1fff; vals[2] = 13'h0000; vals[3] = 13'h0001;
    vals[4] = 13'h0fff; vals[5] = 13'h0064; vals[6] = 13'h1f9c; vals[7] = 13'h0007;
    rst_n = 1'b0; vin = 1'b0; rdy = 1'b0; ovf_clr = 1'b0; din = '0;
    test_reset();
    test_pass_through();
    test_fill_overrun();
    test_ovf_clr();
    test_full_rw();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
